switch_alloc_wormhole: RTL and testbench

- Replaces the stateless per-output round-robin switch control with a wormhole-aware allocator.
- Sits between the N input FIFOs and the N×M crossbar.
- Each output port is locked to one input from the head flit until the tail flit of that packet passes.
- Each output keeps a credit counter that tracks free slots in the downstream router's input buffer.
- Drives the crossbar select and the FIFO read enables.

---
 rtl/swa_pkg.sv | 11 +
 rtl/output_lock_arbiter.sv | 85 ++++++++
 rtl/switch_alloc_wormhole.sv | 72 +++++++
 tb/tb_switch_alloc_wormhole.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/swa_pkg.sv
// Shared sizing, state and credit types for the wormhole switch allocator.
package swa_pkg;
    localparam int N       = 5;
    localparam int M       = 5;
    localparam int CREDITS = 4;
    localparam int CW      = $clog2(CREDITS + 1);
    localparam int IW      = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {IDLE, LOCKED} port_state_t;
    typedef logic [CW-1:0] credit_t;
endpackage

// File: rtl/output_lock_arbiter.sv
// One output port: wormhole lock FSM, round-robin pointer and downstream credit counter.
module output_lock_arbiter
    import swa_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         ce,
    input  logic [N-1:0] req,
    input  logic [N-1:0] tail,
    input  logic         credit_ret,
    output logic [N-1:0] grant,
    output logic         locked,
    output credit_t      credit,
    output logic         err
);
    localparam credit_t       CREDIT_MAX = credit_t'(CREDITS);
    localparam logic [IW-1:0] LAST       = IW'(N - 1);

    port_state_t   state;
    logic [IW-1:0] owner;
    logic [IW-1:0] ptr;
    logic [IW-1:0] pick;
    logic [IW-1:0] idx;
    logic          pick_valid;
    credit_t       credit_q;
    logic          err_q;

    // Grants are combinational from registered state; reset forces them low.
    always_comb begin
        pick_valid = 1'b0;
        pick       = '0;
        idx        = '0;
        if (!reset && ce && credit_q != '0) begin
            if (state == IDLE) begin
                for (int k = 0; k < N; k++) begin
                    idx = (int'(ptr) + k >= N) ? IW'(int'(ptr) + k - N) : IW'(int'(ptr) + k);
                    if (!pick_valid && req[idx]) begin
                        pick_valid = 1'b1;
                        pick       = idx;
                    end
                end
            end else if (req[owner]) begin
                pick_valid = 1'b1;
                pick       = owner;
            end
        end
        grant = '0;
        if (pick_valid) grant[pick] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            owner <= '0;
            ptr   <= '0;
        end else if (pick_valid) begin
            if (state == IDLE) begin
                ptr <= (pick == LAST) ? '0 : pick + 1'b1;
                if (!tail[pick]) begin
                    state <= LOCKED;
                    owner <= pick;
                end
            end else if (tail[pick]) begin
                state <= IDLE;
            end
        end
    end

    // Credits track downstream space even while allocation is stalled by ce.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            credit_q <= CREDIT_MAX;
            err_q    <= 1'b0;
        end else if (pick_valid && !credit_ret) begin
            credit_q <= credit_q - 1'b1;
        end else if (!pick_valid && credit_ret) begin
            if (credit_q == CREDIT_MAX) err_q <= 1'b1;
            else                        credit_q <= credit_q + 1'b1;
        end
    end

    assign locked = (state == LOCKED);
    assign credit = credit_q;
    assign err    = err_q;
endmodule

// File: rtl/switch_alloc_wormhole.sv
// Wormhole switch allocator: conditions requests, runs one lock arbiter per output, merges grants.
module switch_alloc_wormhole
    import swa_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic [0:N-1][0:M-1]   i_output_req,
    input  logic [0:N-1]          i_tail,
    input  logic [0:M-1]          i_credit_ret,
    output logic [0:M-1][0:N-1]   o_output_grant,
    output logic [0:N-1]          o_input_grant,
    output logic [0:M-1]          o_locked,
    output logic [0:M-1][CW-1:0]  o_credit,
    output logic                  o_credit_err
);
    logic [N-1:0] col_req   [M];
    logic [N-1:0] col_grant [M];
    credit_t      col_credit[M];
    logic [M-1:0] col_locked;
    logic [M-1:0] col_err;
    logic [N-1:0] tail_vec;

    // Keep only the lowest-index output per input so an input can win at most one port.
    always_comb begin : reduce_p
        logic seen;
        seen     = 1'b0;
        tail_vec = '0;
        for (int i = 0; i < M; i++) col_req[i] = '0;
        for (int j = 0; j < N; j++) begin
            tail_vec[j] = i_tail[j];
            seen        = 1'b0;
            for (int i = 0; i < M; i++) begin
                if (i_output_req[j][i] && !seen) begin
                    col_req[i][j] = 1'b1;
                    seen          = 1'b1;
                end
            end
        end
    end

    for (genvar i = 0; i < M; i++) begin : g_out
        output_lock_arbiter u_arb (
            .clk        (clk),
            .reset      (reset),
            .ce         (ce),
            .req        (col_req[i]),
            .tail       (tail_vec),
            .credit_ret (i_credit_ret[i]),
            .grant      (col_grant[i]),
            .locked     (col_locked[i]),
            .credit     (col_credit[i]),
            .err        (col_err[i])
        );
    end

    always_comb begin
        o_output_grant = '0;
        o_input_grant  = '0;
        o_locked       = '0;
        o_credit       = '0;
        for (int i = 0; i < M; i++) begin
            o_locked[i] = col_locked[i];
            o_credit[i] = col_credit[i];
            for (int j = 0; j < N; j++) begin
                o_output_grant[i][j] = col_grant[i][j];
                o_input_grant[j]     = o_input_grant[j] | col_grant[i][j];
            end
        end
        o_credit_err = |col_err;
    end
endmodule

// File: tb/tb_switch_alloc_wormhole.sv
// Scoreboard bench for switch_alloc_wormhole: directed wormhole scenarios then randomized traffic.
module tb_switch_alloc_wormhole;
    import swa_pkg::*;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 ce = 1'b0;
    logic [0:N-1][0:M-1]  i_output_req = '0;
    logic [0:N-1]         i_tail = '0;
    logic [0:M-1]         i_credit_ret = '0;
    logic [0:M-1][0:N-1]  o_output_grant;
    logic [0:N-1]         o_input_grant;
    logic [0:M-1]         o_locked;
    logic [0:M-1][CW-1:0] o_credit;
    logic                 o_credit_err;

    typedef struct {
        logic [0:M-1][0:N-1]  og;
        logic [0:N-1]         ig;
        logic [0:M-1]         lk;
        logic [0:M-1][CW-1:0] cr;
        logic                 err;
    } expect_t;

    expect_t sb[$];
    int      checks = 0;
    int      failures = 0;
    int      cycle = 0;

    // Reference model: owner -1 means the output is free.
    int owner[M];
    int ptr[M];
    int cred[M];
    bit model_err;

    switch_alloc_wormhole dut (
        .clk            (clk),
        .reset          (reset),
        .ce             (ce),
        .i_output_req   (i_output_req),
        .i_tail         (i_tail),
        .i_credit_ret   (i_credit_ret),
        .o_output_grant (o_output_grant),
        .o_input_grant  (o_input_grant),
        .o_locked       (o_locked),
        .o_credit       (o_credit),
        .o_credit_err   (o_credit_err)
    );

    always #5 clk = ~clk;

    function automatic logic [0:M-1] oh(input int o);
        logic [0:M-1] r;
        r = '0;
        if (o >= 0) r[o] = 1'b1;
        return r;
    endfunction

    function automatic void modelReset();
        for (int i = 0; i < M; i++) begin
            owner[i] = -1;
            ptr[i]   = 0;
            cred[i]  = CREDITS;
        end
        model_err = 1'b0;
    endfunction

    task automatic applyStimulus(input logic [0:N-1][0:M-1] req, input logic [0:N-1] tl,
                                 input logic [0:M-1] ret, input logic ce_v, input logic rst_v);
        expect_t e;
        int      target[N];
        int      g;
        @(posedge clk);
        #1;
        reset        = rst_v;
        ce           = ce_v;
        i_output_req = req;
        i_tail       = tl;
        i_credit_ret = ret;
        if (rst_v) modelReset();
        e.og  = '0;
        e.ig  = '0;
        e.lk  = '0;
        e.cr  = '0;
        e.err = model_err;
        for (int j = 0; j < N; j++) begin
            target[j] = -1;
            for (int i = M - 1; i >= 0; i--) if (req[j][i]) target[j] = i;
        end
        for (int i = 0; i < M; i++) begin
            e.lk[i] = (owner[i] >= 0);
            e.cr[i] = CW'(cred[i]);
            g = -1;
            if (!rst_v && ce_v && cred[i] > 0) begin
                if (owner[i] < 0) begin
                    for (int k = 0; k < N; k++) begin
                        int jj;
                        jj = (ptr[i] + k) % N;
                        if (g < 0 && target[jj] == i) g = jj;
                    end
                end else if (target[owner[i]] == i) begin
                    g = owner[i];
                end
            end
            if (g >= 0) begin
                e.og[i][g] = 1'b1;
                e.ig[g]    = 1'b1;
            end
            if (!rst_v) begin
                if (g >= 0 && owner[i] < 0) begin
                    ptr[i] = (g + 1) % N;
                    if (!tl[g]) owner[i] = g;
                end else if (g >= 0 && tl[g]) begin
                    owner[i] = -1;
                end
                if (g >= 0 && !ret[i]) cred[i] = cred[i] - 1;
                else if (g < 0 && ret[i]) begin
                    if (cred[i] == CREDITS) model_err = 1'b1;
                    else                    cred[i] = cred[i] + 1;
                end
            end
        end
        sb.push_back(e);
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s cycle=%0d actual=%0h expected=%0h", name, cycle, act, exp);
        end
    endtask

    // Monitor: outputs are stable mid-cycle, so compare on the falling edge.
    initial begin
        expect_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checkOutput("output_grant", 64'(o_output_grant), 64'(e.og));
                checkOutput("input_grant",  64'(o_input_grant),  64'(e.ig));
                checkOutput("locked",       64'(o_locked),       64'(e.lk));
                checkOutput("credit",       64'(o_credit),       64'(e.cr));
                checkOutput("credit_err",   64'(o_credit_err),   64'(e.err));
            end
            cycle++;
        end
    end

    initial begin
        logic [0:N-1][0:M-1] rq;
        logic [0:N-1]        tl;
        logic [0:M-1]        rt;
        logic [0:M-1]        tmp;
        modelReset();
        applyStimulus('0, '0, '0, 1'b1, 1'b1);
        applyStimulus('0, '0, '0, 1'b1, 1'b1);

        // Single packet from input 2 through output 0 drains all credits.
        for (int c = 0; c < 4; c++) begin
            rq = '0; tl = '0;
            rq[2] = oh(0);
            tl[2] = (c == 3);
            applyStimulus(rq, tl, '0, 1'b1, 1'b0);
        end

        // Input 3 waits on output 1 until input 0's tail passes.
        for (int c = 0; c < 5; c++) begin
            rq = '0; tl = '0;
            if (c < 3) rq[0] = oh(1);
            tl[0] = (c == 2);
            rq[3] = oh(1);
            tl[3] = (c == 4);
            applyStimulus(rq, tl, (c > 0) ? oh(1) : '0, 1'b1, 1'b0);
        end

        // Single-flit packets rotate round-robin on output 2.
        for (int c = 0; c < 4; c++) begin
            rq = '0; tl = '1;
            rq[0] = oh(2); rq[1] = oh(2); rq[4] = oh(2);
            applyStimulus(rq, tl, (c > 0) ? oh(2) : '0, 1'b1, 1'b0);
        end

        // Credit starvation mid-packet on output 3.
        for (int c = 0; c < 10; c++) begin
            rq = '0; tl = '0;
            rq[1] = oh(3);
            tl[1] = (c >= 8);
            applyStimulus(rq, tl, (c == 6 || c == 8) ? oh(3) : '0, 1'b1, 1'b0);
        end

        // Same-cycle grant and return, then overflow on output 0.
        applyStimulus('0, '0, oh(0), 1'b1, 1'b0);
        applyStimulus('0, '0, oh(0), 1'b1, 1'b0);
        rq = '0; tl = '1; rq[2] = oh(0);
        applyStimulus(rq, tl, oh(0), 1'b1, 1'b0);
        for (int c = 0; c < 3; c++) applyStimulus('0, '0, oh(0), 1'b1, 1'b0);
        applyStimulus('0, '0, '0, 1'b1, 1'b0);
        applyStimulus('0, '0, '0, 1'b0, 1'b0);

        // Reset while two outputs are locked, then a fresh head.
        rq = '0; tl = '0; rq[0] = oh(0); rq[1] = oh(1);
        applyStimulus(rq, tl, '0, 1'b1, 1'b0);
        applyStimulus(rq, tl, '0, 1'b1, 1'b1);
        rq = '0; rq[2] = oh(4); rq[4] = oh(4);
        applyStimulus(rq, tl, '0, 1'b1, 1'b0);
        applyStimulus('0, '0, '0, 1'b1, 1'b0);

        for (int n = 0; n < 600; n++) begin
            for (int j = 0; j < N; j++) begin
                if ($urandom_range(0, 1) == 0) rq[j] = '0;
                else if ($urandom_range(0, 3) == 0) begin
                    tmp   = M'($urandom);
                    rq[j] = tmp;
                end else rq[j] = oh(int'($urandom_range(0, M - 1)));
                tl[j] = ($urandom_range(0, 2) == 0);
            end
            for (int i = 0; i < M; i++) rt[i] = ($urandom_range(0, 2) == 0);
            applyStimulus(rq, tl, rt, ($urandom_range(0, 9) != 0), (n == 300));
        end
        applyStimulus('0, '0, '0, 1'b1, 1'b0);

        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("[TB] FAIL scoreboard_drain actual=%0d expected=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
